// File: rtl/subtractor32_seq.sv
// subtractor32_seq: multi-cycle A - B - Bin, one CHUNK-bit slice per clock, LSB first.
module subtractor32_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             busy,
    output logic             done
);
    localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("subtractor32_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic [WIDTH-1:0] a_r, b_r, w_r, w_next;
    logic [CHUNK-1:0] a_s, b_s;
    logic [CHUNK:0]   diff;
    logic             last;

    always_comb begin
        a_s    = a_r[cnt*CHUNK +: CHUNK];
        b_s    = b_r[cnt*CHUNK +: CHUNK];
        diff   = {1'b0, a_s} - {1'b0, b_s} - {{CHUNK{1'b0}}, brw};
        w_next = w_r;
        w_next[cnt*CHUNK +: CHUNK] = diff[CHUNK-1:0];
        last   = cnt == CW'(N - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            brw   <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            w_r   <= '0;
            D     <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r   <= A;
                    b_r   <= B;
                    brw   <= Bin;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    w_r <= w_next;
                    brw <= diff[CHUNK];
                    if (last) begin
                        D     <= w_next;
                        Bout  <= diff[CHUNK];
                        V     <= (a_r[WIDTH-1] != b_r[WIDTH-1]) & (w_next[WIDTH-1] != a_r[WIDTH-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_subtractor32_seq.sv
// tb_subtractor32_seq: directed table, reset abort, handshake and random checks at CHUNK=8/4/32.
module tb_subtractor32_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, Bin = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] d8, d4, d32;
    logic        bo8, bo4, bo32, v8, v4, v32, busy8, busy4, busy32, done8, done4, done32;
    int          tests = 0, failed = 0;

    always #5 clk = ~clk;

    subtractor32_seq #(.WIDTH(32), .CHUNK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
        .D(d8), .Bout(bo8), .V(v8), .busy(busy8), .done(done8));
    subtractor32_seq #(.WIDTH(32), .CHUNK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
        .D(d4), .Bout(bo4), .V(v4), .busy(busy4), .done(done4));
    subtractor32_seq #(.WIDTH(32), .CHUNK(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
        .D(d32), .Bout(bo32), .V(v32), .busy(busy32), .done(done32));

    typedef struct {
        logic [31:0] a, b;
        logic        bin;
        logic [31:0] d;
        logic        bo, v;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: {V, Bout, D}
    function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] r;
        r = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        return {(a[31] ^ b[31]) & (r[31] ^ a[31]), r};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input logic [31:0] ed, input logic ebo, input logic ev);
        int l8 = 0, l4 = 0, l32 = 0, n8 = 0, n4 = 0, n32 = 0;
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        check("busy8", busy8, 1);
        check("busy4", busy4, 1);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done8)  begin n8++;  if (l8 == 0)  l8 = c;  end
            if (done4)  begin n4++;  if (l4 == 0)  l4 = c;  end
            if (done32) begin n32++; if (l32 == 0) l32 = c; end
        end
        check("res8",  {d8, bo8, v8},    {ed, ebo, ev});
        check("res4",  {d4, bo4, v4},    {ed, ebo, ev});
        check("res32", {d32, bo32, v32}, {ed, ebo, ev});
        check("lat8",  l8,  4);
        check("lat4",  l4,  8);
        check("lat32", l32, 1);
        check("ndone", {n8[7:0], n4[7:0], n32[7:0]}, 24'h010101);
    endtask

    initial begin
        vec_t        tbl[9];
        logic [31:0] ha[30], hb[30];
        logic        hbin[30];
        logic [33:0] r, hexp;
        int          nd;

        tbl[0] = '{32'd50,        32'd20,        1'b0, 32'd30,        1'b0, 1'b0};
        tbl[1] = '{32'd20,        32'd50,        1'b0, 32'hFFFFFFE2,  1'b1, 1'b0};
        tbl[2] = '{32'd0,         32'd0,         1'b1, 32'hFFFFFFFF,  1'b1, 1'b0};
        tbl[3] = '{32'd73469,     32'd40067,     1'b1, 32'd33401,     1'b0, 1'b0};
        tbl[4] = '{32'd1996,      32'd1995,      1'b1, 32'd0,         1'b0, 1'b0};
        tbl[5] = '{32'h80000000,  32'd1,         1'b0, 32'h7FFFFFFF,  1'b0, 1'b1};
        tbl[6] = '{32'h7FFFFFFF,  32'hFFFFFFFF,  1'b0, 32'h80000000,  1'b1, 1'b1};
        tbl[7] = '{32'h00000100,  32'd1,         1'b0, 32'h000000FF,  1'b0, 1'b0};
        tbl[8] = '{32'h12345678,  32'h12345678,  1'b1, 32'hFFFFFFFF,  1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset8", {d8, bo8, v8, busy8, done8}, 0);
        check("reset4", {d4, bo4, v4, busy4, done4}, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, tbl[i].v);

        // Abort mid-RUN: outputs clear at once and the interrupted op never completes
        @(negedge clk);
        A = 32'd50; B = 32'd20; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort8", {d8, bo8, v8, busy8, done8}, 0);
        check("abort4", {d4, bo4, v4, busy4, done4}, 0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done8 || done4) nd++;
        end
        check("abort_nodone", nd, 0);
        run_op(32'd50, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0);

        // Handshake: start held high, operands change every cycle
        for (int i = 0; i < 30; i++) begin
            ha[i] = $urandom; hb[i] = $urandom; hbin[i] = 1'($urandom_range(0, 1));
        end
        hexp = {2'b00, 32'd30};
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            A = ha[i]; B = hb[i]; Bin = hbin[i]; start = 1'b1;
            @(posedge clk); #1;
            check("hs_done", done8, (i % 6) == 4);
            if ((i % 6) == 4) begin
                hexp = ref_sub(ha[i-4], hb[i-4], hbin[i-4]);
                check("hs_res", {v8, bo8}, hexp[33:32]);
            end
            check("hs_d", d8, hexp[31:0]);
        end
        @(negedge clk) start = 1'b0;
        repeat (16) @(posedge clk);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            logic        bin;
            a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
            if (i % 10 == 0) b = a;
            r = ref_sub(a, b, bin);
            run_op(a, b, bin, r[31:0], r[32], r[33]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/subtractor32_seq.md
Name: subtractor32_seq

Overview:
- Multi-cycle companion to the fulladder32 combinational adder: computes D = A − B − Bin over WIDTH/CHUNK clock cycles, one CHUNK-bit slice per cycle, LSB first, with borrow chained between slices.
- Serves datapaths that trade latency for area. Uses a start/busy/done handshake so a controller FSM can issue operations back-to-back.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits processed per cycle. WIDTH % CHUNK must be 0. Illegal values stop elaboration via a generate-time check.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse. Sampled only in IDLE.
- A  input  WIDTH  minuend. Sampled with start.
- B  input  WIDTH  subtrahend. Sampled with start.
- Bin  input  1  borrow-in. Sampled with start.
- D  output  WIDTH  registered difference
- Bout  output  1  borrow-out. 1 when A < B + Bin, unsigned.
- V  output  1  signed overflow of A − B − Bin
- busy  output  1  high from the accept edge until done is asserted
- done  output  1  one-cycle pulse. D, Bout and V are valid from this cycle.

Behaviour:
- Reset:
  - rst_n low clears, asynchronously, state→IDLE, D=0, Bout=0, V=0, busy=0, done=0, and the internal slice counter, borrow and operand registers.
  - Deassertion takes effect at the next rising edge.
  - Reset during RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE. N = WIDTH/CHUNK.
- IDLE:
  - When start=1 at a rising edge: latch A, B, Bin; counter=0; borrow=Bin; busy=1; go to RUN.
  - When start=0: stay in IDLE.
- RUN, one edge per slice k = counter:
  - {b, d} = A[k] − B[k] − borrow, computed in CHUNK+1 bits.
  - Write d into working-result slice k; borrow ← b.
  - When counter = N−1: go to DONE. Otherwise increment counter.
- On the RUN→DONE edge:
  - D ← completed working result.
  - Bout ← final borrow.
  - V ← (A[MSB] ≠ B[MSB]) & (D[MSB] ≠ A[MSB]), using the latched operands.
  - busy ← 0; done ← 1.
- DONE: lasts exactly one cycle, then returns to IDLE and done ← 0.
- Latency: start sampled at edge t → done high after edge t+N (4 cycles at default parameters).
- Back-to-back throughput: a new start is accepted one cycle after done, i.e. one result every N+2 cycles.
- start while busy=1 or in DONE: ignored. Operands are not re-latched.
- Operand stability: A, B and Bin may change freely after the accept edge; the computation uses only the latched copies.
- Output hold: D, Bout and V change only on the RUN→DONE edge or on reset. They hold the last result throughout IDLE and the next RUN.
- Arithmetic:
  - Modulo 2^WIDTH wrap-around.
  - Bin=1 with A=B gives D = all ones, Bout=1.
  - Bout is the inverse of the carry-out of A + ~B + ~Bin.
- N=1 (CHUNK=WIDTH) is legal: RUN lasts one cycle, done after edge t+1.

Test Plan:
- Reset: rst_n=0 asynchronously, mid-RUN, 2 cycles after accepting A=50, B=20 → outputs drop to 0 immediately, no done. Release reset, start with A=50, B=20, Bin=0 → done 4 cycles later, D=30, Bout=0, V=0.
- Borrow and wrap: A=20, B=50, Bin=0 → D=0xFFFFFFE2, Bout=1, V=0. Then A=0, B=0, Bin=1 → D=0xFFFFFFFF, Bout=1, V=0.
- Borrow-in across slices: A=73469, B=40067, Bin=1 → D=33401, Bout=0. Then A=1996, B=1995, Bin=1 → D=0, Bout=0.
- Signed overflow: A=0x80000000, B=1, Bin=0 → D=0x7FFFFFFF, V=1, Bout=0. Then A=0x7FFFFFFF, B=0xFFFFFFFF → D=0x80000000, V=1, Bout=1.
- Handshake:
  - Hold start=1 continuously, and change A/B every cycle while busy.
  - Required: exactly one done per N+2 cycles, results match the operands latched at each accept edge.
  - Required: D stays stable between done pulses.
- Random regression: 1000 random A/B/Bin at CHUNK=8, 4 and 32, compared against the reference model {Bout, D} = {1'b0, A} − B − Bin, with V checked as specified.
